// File: rtl/mux_varredura.sv
// Registered N-channel multiplexer with manual, dwell-timed scan and round-robin modes.
// The presented channel index (id) and its data (saida) are loaded on the same edge.
module mux_varredura #(
   parameter  int N  = 8,
   parameter  int W  = 4,
   parameter  int DW = 8,
   localparam int SW = $clog2(N)
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [N*W-1:0]  entradas,
   input  logic [SW-1:0]   sel,
   input  logic [1:0]      modo,
   input  logic [N-1:0]    req,
   input  logic [DW-1:0]   dwell,
   input  logic            hold,
   output logic [W-1:0]    saida,
   output logic [SW-1:0]   id,
   output logic            valido,
   output logic            volta
);

   typedef enum logic [1:0] {M_MAN, M_SCAN, M_RR} mode_t;

   localparam logic [SW:0]   N_EXT = N[SW:0];
   localparam logic [SW-1:0] LAST  = SW'(N - 1);

   mode_t          mode_q, mode_d;
   logic [SW-1:0]  id_q, id_d;
   logic [DW-1:0]  cnt_q, cnt_d;
   logic [W-1:0]   saida_q, saida_d;
   logic           valido_q, valido_d;
   logic           volta_q, volta_d;

   logic           chg, ptr_ok, sel_ok, arb, found;
   logic [SW-1:0]  cur, grant;
   int             k;

   always_comb begin
      mode_d   = M_MAN;
      chg      = 1'b0;
      ptr_ok   = ({1'b0, id_q} < N_EXT);
      sel_ok   = ({1'b0, sel} < N_EXT);
      cur      = ptr_ok ? id_q : '0;
      id_d     = id_q;
      cnt_d    = cnt_q;
      valido_d = 1'b1;
      volta_d  = 1'b0;
      saida_d  = '0;
      arb      = 1'b0;
      found    = 1'b0;
      grant    = '0;
      k        = 0;

      if (modo == 2'b01)      mode_d = M_SCAN;
      else if (modo == 2'b10) mode_d = M_RR;
      chg = (mode_d != mode_q);

      // Cyclic search starting after the current channel; the current one is reached last.
      for (int i = 1; i <= N; i++) begin
         k = (int'(cur) + i) % N;
         if (!found && req[k]) begin
            found = 1'b1;
            grant = SW'(k);
         end
      end

      case (mode_d)
         M_SCAN: begin
            id_d = cur;
            if (chg) begin
               cnt_d = '0;
            end else if (!hold) begin
               if (cnt_q >= dwell) begin
                  cnt_d   = '0;
                  id_d    = (cur == LAST) ? '0 : cur + SW'(1);
                  volta_d = (cur == LAST);
               end else begin
                  cnt_d = cnt_q + DW'(1);
               end
            end
         end
         M_RR: begin
            arb = chg || !valido_q || !(ptr_ok && req[id_q]) ||
                  ((cnt_q >= dwell) && !hold);
            if (arb) begin
               cnt_d = '0;
               if (found) begin
                  id_d    = grant;
                  volta_d = (grant <= id_q);
               end else begin
                  valido_d = 1'b0;
               end
            end else if (!hold) begin
               cnt_d = cnt_q + DW'(1);
            end
         end
         default: begin
            id_d     = sel;
            cnt_d    = '0;
            valido_d = sel_ok;
         end
      endcase

      // id_d is always a legal channel whenever valido_d is set.
      if (valido_d) saida_d = entradas[int'(id_d)*W +: W];
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mode_q   <= M_MAN;
         id_q     <= '0;
         cnt_q    <= '0;
         saida_q  <= '0;
         valido_q <= 1'b0;
         volta_q  <= 1'b0;
      end else begin
         mode_q   <= mode_d;
         id_q     <= id_d;
         cnt_q    <= cnt_d;
         saida_q  <= saida_d;
         valido_q <= valido_d;
         volta_q  <= volta_d;
      end
   end

   assign saida  = saida_q;
   assign id     = id_q;
   assign valido = valido_q;
   assign volta  = volta_q;

endmodule
